pc_sequencer: RTL and testbench

//   Sequences the program_counter each cycle: drives its clock enable, reset and taken/immediate inputs.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_seq_if.sv | 41 ++++
 rtl/pc_redirect_buffer.sv | 37 +++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer: FSM state encoding and immediate widths.
package pc_seq_pkg;

  localparam int BR_IMM_W_DEF  = 6;
  localparam int JMP_IMM_W_DEF = 12;
  localparam int FLUSH_CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/pc_seq_if.sv
// Decode/fetch-side inputs and program-counter control outputs of the PC sequencer.
interface pc_seq_if #(
  parameter int BR_IMM_W  = pc_seq_pkg::BR_IMM_W_DEF,
  parameter int JMP_IMM_W = pc_seq_pkg::JMP_IMM_W_DEF
);

  logic                 run_pi;
  logic                 imem_ready_pi;
  logic                 stall_pi;
  logic                 br_valid_pi;
  logic                 br_cond_pi;
  logic [BR_IMM_W-1:0]  br_imm_pi;
  logic                 jmp_valid_pi;
  logic [JMP_IMM_W-1:0] jmp_imm_pi;
  logic                 halt_pi;

  logic                 pc_clk_en_po;
  logic                 pc_reset_po;
  logic                 branch_taken_po;
  logic [BR_IMM_W-1:0]  branch_immediate_po;
  logic                 jump_taken_po;
  logic [JMP_IMM_W-1:0] jump_immediate_po;
  logic                 flush_po;
  logic                 halted_po;
  logic [2:0]           state_po;

  modport slave (
    input  run_pi, imem_ready_pi, stall_pi, br_valid_pi, br_cond_pi, br_imm_pi,
           jmp_valid_pi, jmp_imm_pi, halt_pi,
    output pc_clk_en_po, pc_reset_po, branch_taken_po, branch_immediate_po,
           jump_taken_po, jump_immediate_po, flush_po, halted_po, state_po
  );

  modport master (
    output run_pi, imem_ready_pi, stall_pi, br_valid_pi, br_cond_pi, br_imm_pi,
           jmp_valid_pi, jmp_imm_pi, halt_pi,
    input  pc_clk_en_po, pc_reset_po, branch_taken_po, branch_immediate_po,
           jump_taken_po, jump_immediate_po, flush_po, halted_po, state_po
  );

endinterface

// File: rtl/pc_redirect_buffer.sv
// One-entry holding register for a redirect that arrived while fetch could not take it.
module pc_redirect_buffer #(
  parameter int IMM_W = 12
) (
  input  logic             clk_pi,
  input  logic             reset_pi,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             is_branch_i,
  input  logic [IMM_W-1:0] imm_i,
  output logic             valid_o,
  output logic             is_branch_o,
  output logic [IMM_W-1:0] imm_o
);

  logic             valid_q;
  logic             is_branch_q;
  logic [IMM_W-1:0] imm_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pi) begin
    if (reset_pi || (clear_i && !load_i)) begin
      valid_q     <= 1'b0;
      is_branch_q <= 1'b0;
      imm_q       <= '0;
    end else if (load_i) begin
      valid_q     <= 1'b1;
      is_branch_q <= is_branch_i;
      imm_q       <= imm_i;
    end
  end

  assign valid_o     = valid_q;
  assign is_branch_o = is_branch_q;
  assign imm_o       = imm_q;

endmodule

// File: rtl/pc_sequencer.sv
// Drives the program counter's enable, reset and redirect inputs from decode and fetch status.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int BR_IMM_W     = BR_IMM_W_DEF,
  parameter int JMP_IMM_W    = JMP_IMM_W_DEF,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic     clk_pi,
  input  logic     reset_pi,
  pc_seq_if.slave  bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic                 go, br_hit, redirect;
  logic                 pend_load, pend_clear, pend_valid, pend_is_branch;
  logic [JMP_IMM_W-1:0] pend_imm, capture_imm;

  logic                 clk_en, br_taken, jmp_taken, flush, halted;
  logic [BR_IMM_W-1:0]  br_imm;
  logic [JMP_IMM_W-1:0] jmp_imm;

  assign go       = bus.imem_ready_pi & ~bus.stall_pi;
  assign br_hit   = bus.br_valid_pi & bus.br_cond_pi;
  assign redirect = br_hit | bus.jmp_valid_pi;

  // Branch offsets share the jump-width slot, zero-padded; only the low bits are replayed.
  assign capture_imm = br_hit ? {{(JMP_IMM_W-BR_IMM_W){1'b0}}, bus.br_imm_pi} : bus.jmp_imm_pi;

  pc_redirect_buffer #(.IMM_W(JMP_IMM_W)) u_pending (
    .clk_pi      (clk_pi),
    .reset_pi    (reset_pi),
    .load_i      (pend_load),
    .clear_i     (pend_clear),
    .is_branch_i (br_hit),
    .imm_i       (capture_imm),
    .valid_o     (pend_valid),
    .is_branch_o (pend_is_branch),
    .imm_o       (pend_imm)
  );

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    clk_en      = 1'b0;
    br_taken    = 1'b0;
    br_imm      = '0;
    jmp_taken   = 1'b0;
    jmp_imm     = '0;
    flush       = 1'b0;
    halted      = 1'b0;
    pend_load   = 1'b0;
    pend_clear  = 1'b0;

    unique case (state_q)
      ST_IDLE: if (bus.run_pi) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.halt_pi) begin
          state_d = ST_HALT;
        end else if (redirect && go) begin
          clk_en      = 1'b1;
          br_taken    = br_hit;
          br_imm      = br_hit ? bus.br_imm_pi : '0;
          jmp_taken   = ~br_hit;
          jmp_imm     = br_hit ? '0 : bus.jmp_imm_pi;
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else if (redirect) begin
          pend_load = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          clk_en = go;
        end
      end
      ST_WAIT: begin
        if (go && pend_valid) begin
          clk_en      = 1'b1;
          br_taken    = pend_is_branch;
          br_imm      = pend_is_branch ? pend_imm[BR_IMM_W-1:0] : '0;
          jmp_taken   = ~pend_is_branch;
          jmp_imm     = pend_is_branch ? '0 : pend_imm;
          pend_clear  = 1'b1;
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        flush  = 1'b1;
        clk_en = bus.imem_ready_pi;
        if (flush_cnt_q != '0)      flush_cnt_d = flush_cnt_q - 1'b1;
        else if (bus.imem_ready_pi) state_d     = ST_RUN;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pc_clk_en_po        = clk_en;
  assign bus.pc_reset_po         = reset_pi | (state_q == ST_IDLE);
  assign bus.branch_taken_po     = br_taken;
  assign bus.branch_immediate_po = br_imm;
  assign bus.jump_taken_po       = jmp_taken;
  assign bus.jump_immediate_po   = jmp_imm;
  assign bus.flush_po            = flush;
  assign bus.halted_po           = halted;
  assign bus.state_po            = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against an event-level reference model.
module tb_pc_sequencer;

  localparam int BW = 6;
  localparam int JW = 12;
  localparam int FC = 3;

  typedef struct packed {
    logic          clk_en;
    logic          pc_reset;
    logic          br_t;
    logic [BW-1:0] br_imm;
    logic          j_t;
    logic [JW-1:0] j_imm;
    logic          flush;
    logic          halted;
    logic [2:0]    state;
  } outs_t;

  typedef struct {
    bit          is_br;
    logic [JW-1:0] imm;
  } redir_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pc_track;

  pc_seq_if #(.BR_IMM_W(BW), .JMP_IMM_W(JW)) bus ();

  pc_sequencer #(.BR_IMM_W(BW), .JMP_IMM_W(JW), .FLUSH_CYCLES(FC)) dut (
    .clk_pi   (clk),
    .reset_pi (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: started/halted flags, a queue of deferred redirects, bubble age.
  bit     m_active, m_halted, m_flushing;
  int     m_age;
  redir_t m_pend[$];

  function automatic outs_t model_outs();
    outs_t e;
    bit    go, bt;
    e = '0;
    go = bus.imem_ready_pi && !bus.stall_pi;
    bt = bus.br_valid_pi && bus.br_cond_pi;
    e.pc_reset = rst || !m_active;
    if (!m_active) begin
      e.state = 3'd0;
    end else if (m_halted) begin
      e.state  = 3'd4;
      e.halted = 1'b1;
    end else if (m_flushing) begin
      e.state  = 3'd3;
      e.flush  = 1'b1;
      e.clk_en = bus.imem_ready_pi;
    end else if (m_pend.size() > 0) begin
      e.state = 3'd2;
      if (go) begin
        e.clk_en = 1'b1;
        if (m_pend[0].is_br) begin
          e.br_t   = 1'b1;
          e.br_imm = m_pend[0].imm[BW-1:0];
        end else begin
          e.j_t   = 1'b1;
          e.j_imm = m_pend[0].imm;
        end
      end
    end else begin
      e.state = 3'd1;
      if (!bus.halt_pi) begin
        if (bt && go) begin
          e.clk_en = 1'b1;
          e.br_t   = 1'b1;
          e.br_imm = bus.br_imm_pi;
        end else if (bus.jmp_valid_pi && go) begin
          e.clk_en = 1'b1;
          e.j_t    = 1'b1;
          e.j_imm  = bus.jmp_imm_pi;
        end else if (!bt && !bus.jmp_valid_pi) begin
          e.clk_en = go;
        end
      end
    end
    return e;
  endfunction

  task automatic model_update();
    bit     go, bt;
    redir_t r;
    go = bus.imem_ready_pi && !bus.stall_pi;
    bt = bus.br_valid_pi && bus.br_cond_pi;
    if (rst) begin
      m_active = 0; m_halted = 0; m_flushing = 0; m_age = 0;
      m_pend.delete();
    end else if (!m_active) begin
      m_active = bus.run_pi;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_flushing) begin
      if (m_age >= FC - 1 && bus.imem_ready_pi) m_flushing = 0;
      else m_age++;
    end else if (m_pend.size() > 0) begin
      if (go) begin
        void'(m_pend.pop_front());
        m_flushing = 1; m_age = 0;
      end
    end else if (bus.halt_pi) begin
      m_halted = 1;
    end else if (bt || bus.jmp_valid_pi) begin
      if (go) begin
        m_flushing = 1; m_age = 0;
      end else begin
        r.is_br = bt;
        r.imm   = bt ? JW'(bus.br_imm_pi) : bus.jmp_imm_pi;
        m_pend.push_back(r);
      end
    end
  endtask

  function automatic outs_t dut_outs();
    outs_t g;
    g.clk_en   = bus.pc_clk_en_po;
    g.pc_reset = bus.pc_reset_po;
    g.br_t     = bus.branch_taken_po;
    g.br_imm   = bus.branch_immediate_po;
    g.j_t      = bus.jump_taken_po;
    g.j_imm    = bus.jump_immediate_po;
    g.flush    = bus.flush_po;
    g.halted   = bus.halted_po;
    g.state    = bus.state_po;
    return g;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit run, input bit rdy, input bit stl,
                       input bit bv, input bit bc, input logic [BW-1:0] bi,
                       input bit jv, input logic [JW-1:0] ji, input bit hlt);
    rst = r; bus.run_pi = run; bus.imem_ready_pi = rdy; bus.stall_pi = stl;
    bus.br_valid_pi = bv; bus.br_cond_pi = bc; bus.br_imm_pi = bi;
    bus.jmp_valid_pi = jv; bus.jmp_imm_pi = ji; bus.halt_pi = hlt;
  endtask

  // One cycle: compare combinational outputs mid-cycle, then advance DUT and model together.
  task automatic step(input string tag);
    outs_t e, g;
    #1;
    e = model_outs();
    g = dut_outs();
    check(tag, 64'(g), 64'(e));
    if (g.clk_en) pc_track += 2;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, '0, 0, '0, 0);
    m_active = 0; m_halted = 0; m_flushing = 0; m_age = 0;
    @(posedge clk);
    @(negedge clk);
    step("reset_hold");
    check("reset_pc_reset", 64'(bus.pc_reset_po), 64'd1);

    // 1: start fetching, four sequential enables.
    drive(0, 1, 1, 0, 0, 0, '0, 0, '0, 0);
    pc_track = 0;
    step("t1_idle");
    repeat (4) step("t1_seq");
    check("t1_pc", 64'(pc_track), 64'd8);

    // 2: taken branch with fetch ready, then bubbles.
    drive(0, 1, 1, 0, 1, 1, 6'h3E, 0, '0, 0);
    #1;
    check("t2_br_taken", 64'(bus.branch_taken_po), 64'd1);
    check("t2_br_imm", 64'(bus.branch_immediate_po), 64'h3E);
    step("t2_branch");
    drive(0, 1, 1, 0, 0, 0, '0, 0, '0, 0);
    #1;
    check("t2_flush", 64'(bus.flush_po), 64'd1);
    repeat (FC + 1) step("t2_flush_seq");

    // 3: jump while fetch busy is held, then replayed.
    drive(0, 1, 0, 0, 0, 0, '0, 1, 12'h010, 0);
    step("t3_capture");
    drive(0, 1, 0, 0, 1, 1, 6'h15, 1, 12'h777, 0);
    repeat (2) step("t3_wait");
    drive(0, 1, 1, 0, 0, 0, '0, 0, '0, 0);
    #1;
    check("t3_jmp_taken", 64'(bus.jump_taken_po), 64'd1);
    check("t3_jmp_imm", 64'(bus.jump_immediate_po), 64'h010);
    repeat (FC + 2) step("t3_replay");

    // 4: branch and jump together, branch wins.
    drive(0, 1, 1, 0, 1, 1, 6'h05, 1, 12'hABC, 0);
    #1;
    check("t4_jmp_dropped", 64'(bus.jump_taken_po), 64'd0);
    step("t4_both");
    drive(0, 1, 1, 0, 0, 0, '0, 0, '0, 0);
    repeat (FC + 1) step("t4_flush");

    // 5: halt beats a taken branch and sticks until reset.
    drive(0, 1, 1, 0, 1, 1, 6'h2A, 0, '0, 1);
    step("t5_halt");
    drive(0, 1, 1, 0, 1, 1, 6'h11, 1, 12'h123, 0);
    repeat (3) step("t5_halted");
    check("t5_halted_po", 64'(bus.halted_po), 64'd1);
    drive(1, 0, 1, 0, 0, 0, '0, 0, '0, 0);
    step("t5_reset");
    drive(0, 1, 1, 0, 0, 0, '0, 0, '0, 0);
    step("t5_restart");

    // 6: stall freezes the PC; reset mid-WAIT discards the pending jump.
    drive(0, 1, 1, 1, 0, 0, '0, 0, '0, 0);
    pc_track = 0;
    repeat (2) step("t6_stall");
    check("t6_pc_frozen", 64'(pc_track), 64'd0);
    drive(0, 1, 1, 1, 0, 0, '0, 1, 12'h444, 0);
    step("t6_capture");
    drive(1, 0, 1, 0, 0, 0, '0, 0, '0, 0);
    step("t6_reset_wait");
    drive(0, 0, 1, 0, 0, 0, '0, 0, '0, 0);
    #1;
    check("t6_idle_reset", 64'(bus.pc_reset_po), 64'd1);
    step("t6_idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
            ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 25), 1'($urandom), BW'($urandom),
            ($urandom_range(0, 99) < 20), JW'($urandom),
            ($urandom_range(0, 99) < 3));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
